// File: rtl/boru_hatti_paket.sv
// Shared pipeline definitions: load funct3 codes, write-back FSM states,
// instruction field positions and the load legality check.
package boru_hatti_paket;

    localparam int RD_MSB = 11;
    localparam int RD_LSB = 7;
    localparam int F3_MSB = 14;
    localparam int F3_LSB = 12;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        BOS   = 2'd0,
        ISTEK = 2'd1,
        BEKLE = 2'd2
    } durum_e;

    // A load is rejected for an unknown funct3 or an address that is not
    // aligned to its access size.
    function automatic logic yukleme_hatali(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            F3_LB, F3_LBU: return 1'b0;
            F3_LH, F3_LHU: return a[0];
            F3_LW:         return |a;
            default:       return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/geri_yazma_yukleme_genisletici.sv
// Selects the addressed byte/halfword of a memory word and sign- or
// zero-extends it according to the load funct3.
module yukleme_genisletici
    import boru_hatti_paket::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  serit_i,
    input  logic [31:0] veri_i,
    output logic [31:0] genisletilmis_o
);

    logic [7:0]  bayt;
    logic [15:0] yarim;

    // Lane select followed by extension; unknown codes yield zero.
    always_comb begin
        bayt  = veri_i[8*serit_i +: 8];
        yarim = serit_i[1] ? veri_i[31:16] : veri_i[15:0];
        case (funct3_i)
            F3_LB:   genisletilmis_o = {{24{bayt[7]}}, bayt};
            F3_LH:   genisletilmis_o = {{16{yarim[15]}}, yarim};
            F3_LW:   genisletilmis_o = veri_i;
            F3_LBU:  genisletilmis_o = {24'd0, bayt};
            F3_LHU:  genisletilmis_o = {16'd0, yarim};
            default: genisletilmis_o = '0;
        endcase
    end

endmodule

// File: rtl/geri_yazma.sv
// Write-back stage: retires ALU results in one cycle, runs one load at a
// time against data memory and publishes the in-flight load destination.
module geri_yazma
    import boru_hatti_paket::*;
#(
    parameter int VERI_GENISLIGI = 32,
    parameter int REG_SAYISI     = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      ex_gecerli_i,
    output logic                      ex_hazir_o,
    input  logic [31:0]               ex_buyruk_i,
    input  logic [VERI_GENISLIGI-1:0] ex_sonuc_i,
    input  logic                      ex_yukleme_i,
    input  logic                      ex_yaz_i,
    output logic                      bellek_istek_o,
    output logic [VERI_GENISLIGI-1:0] bellek_adres_o,
    input  logic                      bellek_hazir_i,
    input  logic                      bellek_veri_gecerli_i,
    input  logic [VERI_GENISLIGI-1:0] bellek_veri_i,
    output logic                      regfile_wen_o,
    output logic [4:0]                hedef_reg_adres_o,
    output logic [VERI_GENISLIGI-1:0] sonuc_o,
    output logic [REG_SAYISI-1:0]     bekleyen_reg_o,
    output logic                      hata_o
);

    durum_e durum_q, durum_d;

    logic [4:0]                rd_q, rd_d;
    logic [2:0]                f3_q, f3_d;
    logic [1:0]                serit_q, serit_d;
    logic [VERI_GENISLIGI-1:0] adres_q, adres_d;
    logic                      wen_q, wen_d;
    logic [4:0]                hedef_q, hedef_d;
    logic [VERI_GENISLIGI-1:0] sonuc_q, sonuc_d;
    logic [REG_SAYISI-1:0]     bekleyen_q, bekleyen_d;
    logic                      hata_q, hata_d;

    logic [4:0]                rd_gir;
    logic [2:0]                f3_gir;
    logic                      kabul, hatali, yukleme_basla, yukleme_bitti;
    logic [VERI_GENISLIGI-1:0] genisletilmis;
    logic                      unused_buyruk;

    assign rd_gir        = ex_buyruk_i[RD_MSB:RD_LSB];
    assign f3_gir        = ex_buyruk_i[F3_MSB:F3_LSB];
    assign unused_buyruk = ^{ex_buyruk_i[31:F3_MSB+1], ex_buyruk_i[RD_LSB-1:0]};
    assign kabul         = ex_gecerli_i && ex_hazir_o;
    assign hatali        = yukleme_hatali(f3_gir, ex_sonuc_i[1:0]);
    assign yukleme_basla = kabul && ex_yukleme_i && !hatali;
    assign yukleme_bitti = (durum_q == BEKLE) && bellek_veri_gecerli_i;

    yukleme_genisletici u_genisletici (
        .funct3_i        (f3_q),
        .serit_i         (serit_q),
        .veri_i          (bellek_veri_i),
        .genisletilmis_o (genisletilmis)
    );

    // State register; reset abandons any in-flight load.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) durum_q <= BOS;
        else         durum_q <= durum_d;
    end

    // Next state: one load at a time, request then data.
    always_comb begin
        durum_d = durum_q;
        case (durum_q)
            BOS:     if (yukleme_basla)  durum_d = ISTEK;
            ISTEK:   if (bellek_hazir_i) durum_d = BEKLE;
            BEKLE:   if (bellek_veri_gecerli_i) durum_d = BOS;
            default: durum_d = BOS;
        endcase
    end

    // State-decoded handshake outputs.
    always_comb begin
        ex_hazir_o     = (durum_q == BOS);
        bellek_istek_o = (durum_q == ISTEK);
    end

    // Datapath next-state: write port, pending mask, error pulse, load context.
    always_comb begin
        rd_d       = rd_q;
        f3_d       = f3_q;
        serit_d    = serit_q;
        adres_d    = adres_q;
        wen_d      = 1'b0;
        hata_d     = 1'b0;
        hedef_d    = hedef_q;
        sonuc_d    = sonuc_q;
        bekleyen_d = bekleyen_q;
        if (kabul && !ex_yukleme_i) begin
            wen_d   = ex_yaz_i && (rd_gir != 5'd0);
            hedef_d = rd_gir;
            sonuc_d = ex_sonuc_i;
        end else if (kabul && hatali) begin
            hata_d = 1'b1;
        end else if (yukleme_basla) begin
            rd_d       = rd_gir;
            f3_d       = f3_gir;
            serit_d    = ex_sonuc_i[1:0];
            adres_d    = {ex_sonuc_i[VERI_GENISLIGI-1:2], 2'b00};
            bekleyen_d = (rd_gir != 5'd0) ? ({{(REG_SAYISI-1){1'b0}}, 1'b1} << rd_gir) : '0;
        end
        if (yukleme_bitti) begin
            wen_d      = (rd_q != 5'd0);
            hedef_d    = rd_q;
            sonuc_d    = genisletilmis;
            bekleyen_d = '0;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rd_q       <= '0;
            f3_q       <= '0;
            serit_q    <= '0;
            adres_q    <= '0;
            wen_q      <= 1'b0;
            hedef_q    <= '0;
            sonuc_q    <= '0;
            bekleyen_q <= '0;
            hata_q     <= 1'b0;
        end else begin
            rd_q       <= rd_d;
            f3_q       <= f3_d;
            serit_q    <= serit_d;
            adres_q    <= adres_d;
            wen_q      <= wen_d;
            hedef_q    <= hedef_d;
            sonuc_q    <= sonuc_d;
            bekleyen_q <= bekleyen_d;
            hata_q     <= hata_d;
        end
    end

    assign bellek_adres_o    = adres_q;
    assign regfile_wen_o     = wen_q;
    assign hedef_reg_adres_o = hedef_q;
    assign sonuc_o           = sonuc_q;
    assign bekleyen_reg_o    = bekleyen_q;
    assign hata_o            = hata_q;

endmodule
